// File: rtl/ps2_keyboard_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx_if
// Signal bundle between the PS/2 pins / keyboard driver and ps2_keyboard_rx.
//   rx_en        : receive enable (driver -> receiver)
//   ps2c, ps2d   : raw PS/2 clock and data from the pins
//   letter_case  : 0 = lowercase, 1 = uppercase ASCII letters
//   rx_done_tick : one-cycle pulse per accepted frame
//   rx_data      : last accepted scan-code byte
//   ascii_code   : combinational ASCII translation of rx_data
//   parity_err   : one-cycle pulse on a rejected frame (PS2_PARITY_CHECK_EN only)
// Modports: slave = receiver side, master = driver/pin side.
// ---------------------------------------------------------------------------
interface ps2_keyboard_rx_if;
  logic       rx_en;
  logic       ps2c;
  logic       ps2d;
  logic       letter_case;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [7:0] ascii_code;
`ifdef PS2_PARITY_CHECK_EN
  logic       parity_err;

  modport slave (
    input  rx_en, ps2c, ps2d, letter_case,
    output rx_done_tick, rx_data, ascii_code, parity_err
  );
  modport master (
    output rx_en, ps2c, ps2d, letter_case,
    input  rx_done_tick, rx_data, ascii_code, parity_err
  );
`else
  modport slave (
    input  rx_en, ps2c, ps2d, letter_case,
    output rx_done_tick, rx_data, ascii_code
  );
  modport master (
    output rx_en, ps2c, ps2d, letter_case,
    input  rx_done_tick, rx_data, ascii_code
  );
`endif
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx
// PS/2 keyboard receive front end: synchronises and deglitches ps2c,
// deserialises 11-bit device-to-host frames, presents the scan code with a
// one-cycle done tick and translates it (Set 2) to ASCII.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous reset, active low
//   bus   : ps2_keyboard_rx_if.slave (rx_en, ps2c, ps2d, letter_case in;
//           rx_done_tick, rx_data, ascii_code [, parity_err] out)
// Optional feature macro: PS2_PARITY_CHECK_EN -- when defined, frames with a
// bad stop bit or even parity are rejected and parity_err pulses instead.
// ---------------------------------------------------------------------------
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              reset,
  ps2_keyboard_rx_if.slave  bus
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FRAME_W = 11;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_e;

  logic                  ps2c_meta_q, ps2c_sync_q;
  logic                  ps2d_meta_q, ps2d_sync_q;
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  fclk_q, fclk_d;
  logic                  fall_c;

  state_e                state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [7:0]            rx_data_q;
  logic                  rx_done_tick_q;
  logic [7:0]            ascii_c;
  logic [7:0]            letter_c;
  logic                  unused_start_c;
`ifdef PS2_PARITY_CHECK_EN
  logic                  parity_err_q;
`endif

  // Synchronisers and clock deglitch filter; all idle-high out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      filter_q    <= '1;
      fclk_q      <= 1'b1;
    end else begin
      ps2c_meta_q <= bus.ps2c;
      ps2c_sync_q <= ps2c_meta_q;
      ps2d_meta_q <= bus.ps2d;
      ps2d_sync_q <= ps2d_meta_q;
      filter_q    <= filter_d;
      fclk_q      <= fclk_d;
    end
  end

  // Filtered clock switches only on a fully settled filter window.
  always_comb begin
    filter_d = {ps2c_sync_q, filter_q[FILTER_LEN-1:1]};
    fclk_d   = fclk_q;
    if (filter_d == '1) begin
      fclk_d = 1'b1;
    end else if (filter_d == '0) begin
      fclk_d = 1'b0;
    end
    fall_c  = fclk_q & ~fclk_d;
    frame_d = {ps2d_sync_q, frame_q[FRAME_W-1:1]};
  end

  // The start bit ends up in frame_q[0] and is deliberately not checked.
  assign unused_start_c = frame_q[0];

  // Receive FSM; rx_done_tick is set on the edge entering LOAD so it is
  // high exactly while the FSM sits in LOAD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      tmo_q          <= '0;
      frame_q        <= '0;
      rx_data_q      <= 8'h00;
      rx_done_tick_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_err_q   <= 1'b0;
`endif
    end else begin
      rx_done_tick_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (fall_c && bus.rx_en) begin
            frame_q   <= frame_d;
            bit_cnt_q <= CNT_W'(9);
            state_q   <= DPS;
          end
        end
        DPS: begin
          if (fall_c) begin
            frame_q <= frame_d;
            tmo_q   <= '0;
            if (bit_cnt_q == '0) begin
              state_q <= LOAD;
`ifdef PS2_PARITY_CHECK_EN
              // Stop bit must be 1 and data+parity must have odd weight.
              if (frame_d[10] && (^frame_d[9:1])) begin
                rx_data_q      <= frame_d[8:1];
                rx_done_tick_q <= 1'b1;
              end else begin
                parity_err_q   <= 1'b1;
              end
`else
              rx_data_q      <= frame_d[8:1];
              rx_done_tick_q <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q - CNT_W'(1);
            end
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Device stopped clocking mid-frame: drop the partial frame.
            state_q   <= IDLE;
            tmo_q     <= '0;
            bit_cnt_q <= '0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        LOAD: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Set-2 scan code to ASCII; letters are resolved to lowercase first.
  always_comb begin
    ascii_c  = 8'h00;
    letter_c = 8'h00;
    case (rx_data_q)
      8'h1C: letter_c = 8'h61;
      8'h32: letter_c = 8'h62;
      8'h21: letter_c = 8'h63;
      8'h23: letter_c = 8'h64;
      8'h24: letter_c = 8'h65;
      8'h2B: letter_c = 8'h66;
      8'h34: letter_c = 8'h67;
      8'h33: letter_c = 8'h68;
      8'h43: letter_c = 8'h69;
      8'h3B: letter_c = 8'h6A;
      8'h42: letter_c = 8'h6B;
      8'h4B: letter_c = 8'h6C;
      8'h3A: letter_c = 8'h6D;
      8'h31: letter_c = 8'h6E;
      8'h44: letter_c = 8'h6F;
      8'h4D: letter_c = 8'h70;
      8'h15: letter_c = 8'h71;
      8'h2D: letter_c = 8'h72;
      8'h1B: letter_c = 8'h73;
      8'h2C: letter_c = 8'h74;
      8'h3C: letter_c = 8'h75;
      8'h2A: letter_c = 8'h76;
      8'h1D: letter_c = 8'h77;
      8'h22: letter_c = 8'h78;
      8'h35: letter_c = 8'h79;
      8'h1A: letter_c = 8'h7A;
      8'h45: ascii_c  = 8'h30;
      8'h16: ascii_c  = 8'h31;
      8'h1E: ascii_c  = 8'h32;
      8'h26: ascii_c  = 8'h33;
      8'h25: ascii_c  = 8'h34;
      8'h2E: ascii_c  = 8'h35;
      8'h36: ascii_c  = 8'h36;
      8'h3D: ascii_c  = 8'h37;
      8'h3E: ascii_c  = 8'h38;
      8'h46: ascii_c  = 8'h39;
      8'h29: ascii_c  = 8'h20;
      8'h5A: ascii_c  = 8'h0D;
      8'h66: ascii_c  = 8'h08;
      default: ascii_c = 8'h00;
    endcase
    if (letter_c != 8'h00) begin
      ascii_c = bus.letter_case ? (letter_c - 8'h20) : letter_c;
    end
  end

  assign bus.rx_done_tick = rx_done_tick_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.ascii_code   = ascii_c;
`ifdef PS2_PARITY_CHECK_EN
  assign bus.parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_rx
// Directed bench for ps2_keyboard_rx: a table of scan-code frames with
// expected rx_data/ascii_code, plus hand-written sequences for reset, glitch,
// rx_en gating, back-to-back frames, mid-frame timeout and mid-frame reset.
// The PS/2 clock is scaled down (40 clk per bit) and TIMEOUT_CYCLES is
// shortened so the run stays short.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

  localparam int unsigned FILTER_LEN     = 8;
  localparam int unsigned TIMEOUT_CYCLES = 300;

  logic clk;
  logic reset;

  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Tick monitor, sampled on the falling edge.
  int         tick_cnt    = 0;
  int         double_tick = 0;
  int         perr_cnt    = 0;
  logic       prev_tick   = 1'b0;
  logic [7:0] tick_log[$];

  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      tick_cnt = tick_cnt + 1;
      tick_log.push_back(bus.rx_data);
      if (prev_tick) double_tick = double_tick + 1;
    end
    prev_tick = (bus.rx_done_tick === 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    if (bus.parity_err === 1'b1) perr_cnt = perr_cnt + 1;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits bits of a frame: start, d0..d7, parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic p, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = fr[i];
      cyc(10);
      bus.ps2c = 1'b0;
      cyc(20);
      bus.ps2c = 1'b1;
      cyc(10);
    end
    bus.ps2d = 1'b1;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  typedef struct {
    logic [7:0] code;
    logic       lc;
    logic [7:0] exp_ascii;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n0;
    logic [7:0] last;

    vecs[0] = '{8'h1C, 1'b0, 8'h61};
    vecs[1] = '{8'h1C, 1'b1, 8'h41};
    vecs[2] = '{8'hF0, 1'b0, 8'h00};
    vecs[3] = '{8'h45, 1'b1, 8'h30};
    vecs[4] = '{8'h29, 1'b0, 8'h20};
    vecs[5] = '{8'h5A, 1'b1, 8'h0D};
    vecs[6] = '{8'h1A, 1'b1, 8'h5A};
    vecs[7] = '{8'h66, 1'b0, 8'h08};
    vecs[8] = '{8'h4D, 1'b0, 8'h70};
    vecs[9] = '{8'hE0, 1'b0, 8'h00};

    bus.rx_en       = 1'b1;
    bus.ps2c        = 1'b1;
    bus.ps2d        = 1'b1;
    bus.letter_case = 1'b0;
    reset           = 1'b0;
    cyc(4);
    check("reset_tick", 32'(bus.rx_done_tick), 32'h0);
    check("reset_rx_data", 32'(bus.rx_data), 32'h00);
    check("reset_ascii", 32'(bus.ascii_code), 32'h00);
    reset = 1'b1;
    cyc(1000);
    check("idle_no_tick", 32'(tick_cnt), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 10; i++) begin
      n0 = tick_cnt;
      bus.letter_case = vecs[i].lc;
      send_frame(vecs[i].code, odd_par(vecs[i].code), 11);
      cyc(5);
      check($sformatf("vec%0d_ticks", i), 32'(tick_cnt - n0), 32'd1);
      last = (tick_log.size() > 0) ? tick_log[tick_log.size()-1] : 8'hXX;
      check($sformatf("vec%0d_tick_data", i), 32'(last), 32'(vecs[i].code));
      check($sformatf("vec%0d_rx_data", i), 32'(bus.rx_data), 32'(vecs[i].code));
      check($sformatf("vec%0d_ascii", i), 32'(bus.ascii_code), 32'(vecs[i].exp_ascii));
    end

    // letter_case acts combinationally on the held byte.
    send_frame(8'h1C, 1'b0, 11);
    bus.letter_case = 1'b0;
    cyc(5);
    check("case_lower", 32'(bus.ascii_code), 32'h61);
    bus.letter_case = 1'b1;
    cyc(1);
    check("case_upper", 32'(bus.ascii_code), 32'h41);
    bus.letter_case = 1'b0;

    // Back-to-back F0, 45.
    n0 = tick_cnt;
    tick_log.delete();
    send_frame(8'hF0, odd_par(8'hF0), 11);
    cyc(2);
    check("b2b_first_ascii", 32'(bus.ascii_code), 32'h00);
    send_frame(8'h45, odd_par(8'h45), 11);
    cyc(5);
    check("b2b_ticks", 32'(tick_cnt - n0), 32'd2);
    last = (tick_log.size() > 0) ? tick_log[0] : 8'hXX;
    check("b2b_first_data", 32'(last), 32'hF0);
    check("b2b_second_data", 32'(bus.rx_data), 32'h45);
    check("b2b_second_ascii", 32'(bus.ascii_code), 32'h30);

    // 3-cycle glitch low on ps2c while idle.
    n0 = tick_cnt;
    bus.ps2c = 1'b0;
    cyc(3);
    bus.ps2c = 1'b1;
    cyc(100);
    check("glitch_no_tick", 32'(tick_cnt - n0), 32'd0);

    // A full frame with rx_en low is ignored.
    bus.rx_en = 1'b0;
    send_frame(8'h1C, odd_par(8'h1C), 11);
    cyc(20);
    bus.rx_en = 1'b1;
    cyc(20);
    check("rxen_no_tick", 32'(tick_cnt - n0), 32'd0);
    check("rxen_data_held", 32'(bus.rx_data), 32'h45);

    // Partial frame abandoned by timeout, then a clean frame.
    n0 = tick_cnt;
    send_frame(8'h1C, odd_par(8'h1C), 5);
    cyc(TIMEOUT_CYCLES + 100);
    check("tmo_no_tick", 32'(tick_cnt - n0), 32'd0);
    send_frame(8'h29, odd_par(8'h29), 11);
    cyc(5);
    check("tmo_then_ticks", 32'(tick_cnt - n0), 32'd1);
    check("tmo_then_data", 32'(bus.rx_data), 32'h29);
    check("tmo_then_ascii", 32'(bus.ascii_code), 32'h20);

    // Reset mid-frame aborts it.
    n0 = tick_cnt;
    send_frame(8'h1C, odd_par(8'h1C), 6);
    reset = 1'b0;
    cyc(2);
    check("midrst_rx_data", 32'(bus.rx_data), 32'h00);
    reset = 1'b1;
    cyc(50);
    check("midrst_no_tick", 32'(tick_cnt - n0), 32'd0);
    send_frame(8'h1C, odd_par(8'h1C), 11);
    cyc(5);
    check("midrst_recover_ticks", 32'(tick_cnt - n0), 32'd1);
    check("midrst_recover_data", 32'(bus.rx_data), 32'h1C);

`ifdef PS2_PARITY_CHECK_EN
    check("perr_none_on_good", 32'(perr_cnt), 32'd0);
    n0 = tick_cnt;
    send_frame(8'h1C, 1'b1, 11);
    cyc(5);
    check("perr_pulse", 32'(perr_cnt), 32'd1);
    check("perr_no_tick", 32'(tick_cnt - n0), 32'd0);
    check("perr_data_held", 32'(bus.rx_data), 32'h1C);
`endif

    check("tick_single_cycle", 32'(double_tick), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receive front end. Deglitches the PS/2 clock, deserialises 11-bit device-to-host frames, and presents the scan-code byte with a one-cycle done tick.
- A combinational Set-2 scan-code to ASCII translator on the received byte is included.
- Sits between the board PS/2 pins and the keyboard driver logic, which handles make/break (F0) tracking.

Parameters:
- FILTER_LEN, 8: length of the ps2c deglitch shift register, in clk samples.
- TIMEOUT_CYCLES, 20000: clk cycles without a ps2c falling edge mid-frame before the frame is abandoned.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous reset, active-low (reset=0 resets).
- rx_en  in  1  receive enable; a new frame may start only while rx_en=1.
- ps2c  in  1  raw PS/2 clock from the pin (asynchronous).
- ps2d  in  1  raw PS/2 data from the pin (asynchronous).
- letter_case  in  1  0 = lowercase letters, 1 = uppercase letters.
- rx_done_tick  out  1  one-clk pulse when a frame is accepted.
- rx_data  out  8  last accepted scan-code byte.
- ascii_code  out  8  combinational ASCII translation of rx_data.

Behaviour:
- Synchronisation: ps2c and ps2d each pass through a 2-flop synchroniser.
- Clock filter:
  - The synced ps2c shifts into a FILTER_LEN-bit register.
  - The filtered clock goes to 1 when the register is all ones, goes to 0 when it is all zeros, and otherwise holds.
  - fall = filtered clock was 1 in the previous cycle and is 0 now (single-cycle strobe).
- Frame format: start(0), d0..d7 (LSB first), odd parity, stop(1). All 11 bits are sampled from synced ps2d on a fall strobe.
- FSM states: IDLE, DPS, LOAD.
  - IDLE: on fall with rx_en=1, shift in the start bit, load bit counter = 9, go to DPS. Falls while rx_en=0 are ignored.
  - DPS: on each fall, right-shift ps2d into an 11-bit frame register. If the counter is 0, go to LOAD; otherwise decrement it.
  - DPS timeout: TIMEOUT_CYCLES clocks with no fall sends the FSM to IDLE with no tick, and the partial frame is discarded. The timeout counter clears on every fall.
  - LOAD: for one cycle, rx_done_tick=1 and rx_data <= frame[8:1]; then go to IDLE.
- Start/stop bits are not checked. Parity is not checked in the default build.
- rx_data holds its value until the next accepted frame.
- Reset values:
  - state IDLE, counters 0, rx_done_tick 0, rx_data 8'h00.
  - Synchronisers, filter register and filtered clock all 1 (bus idle high), so no spurious fall occurs after reset.
- Reset mid-frame aborts the frame with no tick.
- Latency: about 2 + FILTER_LEN clk cycles from the physical 11th falling edge to LOAD. rx_done_tick asserts exactly 1 cycle after the last fall strobe.
- ASCII map (Set 2; letters use 'a'-'z' when letter_case=0 and 'A'-'Z' when letter_case=1):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Other keys: 29 space (8'h20), 5A enter (8'h0D), 66 backspace (8'h08).
  - Any other code, including F0 and E0, gives 8'h00.
  - Digits and other keys ignore letter_case.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- When defined:
  - In LOAD, the frame is accepted only if frame[10]=1 (stop) and d0..d7 plus parity have odd weight.
  - On failure: no rx_done_tick, rx_data unchanged, and an extra output parity_err (1 bit, reset 0) pulses for one cycle.
- When undefined: parity_err does not exist, and every completed frame is accepted.

Test Plan:
- Reset with reset=0 for 4 cycles, lines idle high -> rx_done_tick=0, rx_data=8'h00, ascii_code=8'h00, no tick for 1000 cycles.
- Frame 8'h1C (parity 0) at a 10 kHz PS/2 clock, letter_case=0 -> one 1-cycle rx_done_tick, rx_data=8'h1C, ascii_code=8'h61 ('a'); with letter_case=1 -> 8'h41.
- Frames F0 then 45 back-to-back -> two ticks; rx_data=8'hF0 (ascii 8'h00), then 8'h45 (ascii 8'h30).
- 3-clk glitch low on ps2c while idle, and rx_en=0 during a full frame -> no tick, rx_data unchanged.
- Stop ps2c after 5 bits for more than TIMEOUT_CYCLES, then send 8'h29 -> no tick for the partial frame, then tick with rx_data=8'h29, ascii_code=8'h20.
- With PS2_PARITY_CHECK_EN: frame 8'h1C with parity bit 1 -> parity_err pulse, no tick, rx_data keeps its prior value.
